// File: rtl/ologic_align_seq.sv
// OLOGIC bring-up sequencer: waits for a stable PLL lock, pulses the SerDes reset,
// then toggles align_ol on each lane in turn before asserting phy_ready.
module ologic_align_seq #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned LOCK_STABLE   = 8,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned ALIGN_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 gsclk_ol,
    input  logic                 rst_n,
    input  logic                 pll_lock,
    input  logic                 start,
    input  logic                 retrain,
    output logic                 serdes_rst,
    output logic                 align_ol,
    output logic [NUM_LANES-1:0] lane_en,
    output logic                 phy_ready,
    output logic                 busy,
    output logic [7:0]           relock_cnt
);

    localparam int unsigned LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned MAX_AB  = (LOCK_STABLE > RST_CYCLES) ? LOCK_STABLE : RST_CYCLES;
    localparam int unsigned MAX_CD  = (ALIGN_CYCLES > SETTLE_CYCLES) ? ALIGN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ALIGN_LAST  = CNT_W'(ALIGN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOCK_WAIT,
        SRST,
        ALIGN,
        SETTLE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [7:0]           relock_q, relock_d;
    logic                 serdes_rst_q, serdes_rst_d;
    logic                 align_ol_q, align_ol_d;
    logic [NUM_LANES-1:0] lane_en_q, lane_en_d;
    logic                 phy_ready_q, phy_ready_d;
    logic                 busy_q, busy_d;
    logic                 lock_lost;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        lane_d    = lane_q;
        relock_d  = relock_q;
        lock_lost = !pll_lock && (state_q inside {SRST, ALIGN, SETTLE, DONE});

        // Lock loss outranks every other transition, including retrain in DONE.
        if (lock_lost) begin
            state_d = LOCK_WAIT;
            cnt_d   = '0;
            lane_d  = '0;
            if (relock_q != 8'hFF) begin
                relock_d = relock_q + 8'd1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (start) begin
                        state_d = LOCK_WAIT;
                    end
                end
                LOCK_WAIT: begin
                    if (!pll_lock) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = SRST;
                        cnt_d   = '0;
                    end
                end
                SRST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ALIGN;
                        cnt_d   = '0;
                        lane_d  = '0;
                    end
                end
                ALIGN: begin
                    if (cnt_q == ALIGN_LAST) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d = '0;
                        if (lane_q == LANE_LAST) begin
                            state_d = DONE;
                        end else begin
                            state_d = ALIGN;
                            lane_d  = lane_q + LANE_W'(1);
                        end
                    end
                end
                DONE: begin
                    cnt_d = '0;
                    if (retrain) begin
                        state_d = SRST;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    lane_d  = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they are valid on state entry.
        serdes_rst_d = 1'b0;
        align_ol_d   = 1'b0;
        lane_en_d    = '0;
        phy_ready_d  = 1'b0;
        busy_d       = 1'b1;
        case (state_d)
            IDLE: begin
                serdes_rst_d = 1'b1;
                busy_d       = 1'b0;
            end
            LOCK_WAIT, SRST: serdes_rst_d = 1'b1;
            ALIGN: begin
                lane_en_d[lane_d] = 1'b1;
                align_ol_d        = (state_q == ALIGN) ? !align_ol_q : 1'b1;
            end
            SETTLE: ;
            DONE: begin
                phy_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                serdes_rst_d = 1'b1;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge gsclk_ol) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lane_q       <= '0;
            relock_q     <= '0;
            serdes_rst_q <= 1'b1;
            align_ol_q   <= 1'b0;
            lane_en_q    <= '0;
            phy_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            relock_q     <= relock_d;
            serdes_rst_q <= serdes_rst_d;
            align_ol_q   <= align_ol_d;
            lane_en_q    <= lane_en_d;
            phy_ready_q  <= phy_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign serdes_rst = serdes_rst_q;
    assign align_ol   = align_ol_q;
    assign lane_en    = lane_en_q;
    assign phy_ready  = phy_ready_q;
    assign busy       = busy_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_ologic_align_seq.sv
// Directed bench for ologic_align_seq with default parameters; expected output
// vectors come from a hand-derived cycle timeline of the alignment sequence.
module tb_ologic_align_seq;

    logic       gsclk_ol = 1'b0;
    logic       rst_n, pll_lock, start, retrain;
    logic       serdes_rst, align_ol, phy_ready, busy;
    logic [3:0] lane_en;
    logic [7:0] relock_cnt;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    ologic_align_seq #(
        .NUM_LANES(4),
        .LOCK_STABLE(8),
        .RST_CYCLES(4),
        .ALIGN_CYCLES(4),
        .SETTLE_CYCLES(2)
    ) dut (
        .gsclk_ol(gsclk_ol),
        .rst_n(rst_n),
        .pll_lock(pll_lock),
        .start(start),
        .retrain(retrain),
        .serdes_rst(serdes_rst),
        .align_ol(align_ol),
        .lane_en(lane_en),
        .phy_ready(phy_ready),
        .busy(busy),
        .relock_cnt(relock_cnt)
    );

    always #5 gsclk_ol = ~gsclk_ol;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge gsclk_ol);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, serdes_rst, align_ol, lane_en, phy_ready, busy};
    endfunction

    // {serdes_rst, align_ol, lane_en[3:0], phy_ready, busy} at cycle k after start is
    // sampled: 1..8 lock wait, 9..12 SerDes reset, 13..36 four lanes of 4+2, 37 done.
    function automatic logic [31:0] exp_out(input int k);
        int j, ln, p;
        if (k <= 12) return 32'b1_0_0000_0_1;
        if (k >= 37) return 32'b0_0_0000_1_0;
        j  = k - 13;
        ln = j / 6;
        p  = j % 6;
        if (p < 4) return {24'd0, 1'b0, (p % 2 == 0), 4'(1 << ln), 1'b0, 1'b1};
        return 32'b0_0_0000_0_1;
    endfunction

    task automatic run_timeline(input int k0, input int k1, input string tag);
        for (int k = k0; k <= k1; k++) begin
            check($sformatf("%s_c%0d", tag, k), outs(), exp_out(k));
            if (k != k1) step();
        end
    endtask

    localparam logic [31:0] RESET_OUTS = 32'b1_0_0000_0_0;

    initial begin
        rst_n = 1'b0; pll_lock = 1'b1; start = 1'b0; retrain = 1'b0;
        repeat (3) step();
        check("rst_outs", outs(), RESET_OUTS);
        check("rst_relock", 32'(relock_cnt), 32'd0);

        // IDLE ignores retrain and waits for start.
        rst_n = 1'b1; retrain = 1'b1;
        repeat (3) step();
        check("idle_retrain", outs(), RESET_OUTS);

        // Nominal run with retrain held high (ignored outside DONE) and start held.
        start = 1'b1;
        step();
        run_timeline(1, 37, "nom");
        retrain = 1'b0; start = 1'b0;
        check("nom_relock", 32'(relock_cnt), 32'd0);

        // Retrain: straight into SRST, start ignored throughout.
        retrain = 1'b1; start = 1'b1;
        step();
        retrain = 1'b0;
        run_timeline(9, 37, "rtr");
        start = 1'b0;
        check("rtr_relock", 32'(relock_cnt), 32'd0);

        // Lock loss during lane 2 ALIGN, then full restart from lane 0.
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        run_timeline(9, 26, "pre_loss");
        pll_lock = 1'b0;
        step();
        check("loss_outs", outs(), 32'b1_0_0000_0_1);
        check("loss_relock", 32'(relock_cnt), 32'd1);
        pll_lock = 1'b1;
        run_timeline(1, 37, "relock");

        // Lock loss and retrain together in DONE: lock loss wins.
        retrain = 1'b1; pll_lock = 1'b0;
        step();
        retrain = 1'b0; pll_lock = 1'b1;
        check("sim_relock", 32'(relock_cnt), 32'd2);
        run_timeline(1, 37, "sim");

        // Reset during SETTLE of lane 1.
        retrain = 1'b1;
        step();
        retrain = 1'b0;
        run_timeline(9, 23, "pre_rst");
        rst_n = 1'b0;
        step();
        check("mid_rst_outs", outs(), RESET_OUTS);
        check("mid_rst_relock", 32'(relock_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (4) step();
        check("post_rst_idle", outs(), RESET_OUTS);

        // One-cycle lock glitch at LOCK_WAIT cycle 5 restarts the stability count.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        repeat (11) step();
        check("glitch_c17", outs(), exp_out(12));
        step();
        run_timeline(13, 37, "glitch");
        check("glitch_relock", 32'(relock_cnt), 32'd0);

        // 300 lock-loss events: counter saturates at 255.
        pll_lock = 1'b0;
        step();
        check("sat_ev1", 32'(relock_cnt), 32'd1);
        for (int i = 2; i <= 300; i++) begin
            pll_lock = 1'b1;
            repeat (8) step();
            pll_lock = 1'b0;
            step();
            if (i == 254 || i == 255 || i == 256 || i == 300)
                check($sformatf("sat_ev%0d", i), 32'(relock_cnt), (i >= 255) ? 32'd255 : 32'(i));
        end
        check("sat_outs", outs(), 32'b1_0_0000_0_1);
        pll_lock = 1'b1;
        rst_n = 1'b0;
        step();
        check("final_rst_relock", 32'(relock_cnt), 32'd0);
        check("final_rst_outs", outs(), RESET_OUTS);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
